// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: picks up to two ready entries per cycle
// in round-robin order, honouring ALU/MULT/LSQ unit limits and CDB slot usage.
module rs_issue_sched #(
  parameter int NUM_RS_ENTRIES = 16,
  parameter int MULT_LAT       = 4,
  localparam int IDX_W         = $clog2(NUM_RS_ENTRIES),
  localparam int CNT_W         = $clog2(MULT_LAT) + 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_RS_ENTRIES-1:0]   entry_valid,
  input  logic [NUM_RS_ENTRIES-1:0]   entry_ready,
  input  logic [2*NUM_RS_ENTRIES-1:0] entry_fu,
  input  logic                        lsq_ready,
  input  logic                        issue_stall,
  input  logic                        flush,
  output logic [1:0]                  issue_valid,
  output logic [2*IDX_W-1:0]          issue_idx,
  output logic [3:0]                  issue_fu,
  output logic [NUM_RS_ENTRIES-1:0]   entry_clear,
  output logic                        mult_busy
);

  localparam logic [1:0] FU_ALU  = 2'd0;
  localparam logic [1:0] FU_MULT = 2'd1;
  localparam logic [1:0] FU_LSQ  = 2'd2;

  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] mult_cnt;

  logic [NUM_RS_ENTRIES-1:0] grant;
  logic [IDX_W-1:0]          s_idx [2];
  logic [1:0]                s_fu  [2];
  logic [1:0]                n_grant;
  logic [1:0]                cap;
  logic                      mult_take;
  logic                      lsq_take;
  logic                      allow;
  logic [IDX_W-1:0]          last_idx;
  logic [IDX_W-1:0]          idx;
  logic [1:0]                fu;
  logic                      ok;

  // Reset gating here keeps every output at zero while reset_n is low.
  assign allow = reset_n && !issue_stall && !flush;

  always_comb begin
    grant     = '0;
    s_idx[0]  = '0;
    s_idx[1]  = '0;
    s_fu[0]   = '0;
    s_fu[1]   = '0;
    n_grant   = '0;
    mult_take = 1'b0;
    lsq_take  = 1'b0;
    last_idx  = rr_ptr;
    idx       = '0;
    fu        = '0;
    ok        = 1'b0;
    // A multiply leaving next cycle takes one of the two CDB slots.
    cap       = (mult_cnt == CNT_W'(1)) ? 2'd1 : 2'd2;
    for (int unsigned i = 0; i < NUM_RS_ENTRIES; i++) begin
      idx = rr_ptr + IDX_W'(i);
      fu  = entry_fu[{idx, 1'b0} +: 2];
      ok  = allow && entry_valid[idx] && entry_ready[idx] && (n_grant < cap);
      case (fu)
        FU_ALU:  ;
        FU_MULT: ok = ok && (mult_cnt <= CNT_W'(1)) && !mult_take;
        FU_LSQ:  ok = ok && lsq_ready && !lsq_take;
        default: ok = 1'b0;
      endcase
      if (ok) begin
        grant[idx] = 1'b1;
        if (n_grant == 2'd0) begin
          s_idx[0] = idx;
          s_fu[0]  = fu;
        end else begin
          s_idx[1] = idx;
          s_fu[1]  = fu;
        end
        n_grant   = n_grant + 2'd1;
        last_idx  = idx;
        mult_take = mult_take || (fu == FU_MULT);
        lsq_take  = lsq_take  || (fu == FU_LSQ);
      end
    end
  end

  assign issue_valid = {n_grant == 2'd2, n_grant != 2'd0};
  assign issue_idx   = {s_idx[1], s_idx[0]};
  assign issue_fu    = {s_fu[1], s_fu[0]};
  assign entry_clear = grant;
  assign mult_busy   = (mult_cnt != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      mult_cnt <= '0;
    end else begin
      if (n_grant != 2'd0)
        rr_ptr <= last_idx + 1'b1;
      if (flush)
        mult_cnt <= '0;
      else if (mult_take)
        mult_cnt <= CNT_W'(MULT_LAT - 1);
      else if (mult_cnt != '0)
        mult_cnt <= mult_cnt - 1'b1;
    end
  end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for the 2-way superscalar reservation station. Each cycle it inspects RS entry state and selects up to two operand-ready entries to issue. It enforces functional-unit limits: two ALUs, one non-pipelined multiplier, and one LSQ port. It also keeps CDB slot usage within two broadcasts per cycle, and it rotates priority round-robin across entries. It sits between the RS entry array and the RS→issue pipeline register, and it returns the one-hot clear vector that frees issued entries.

## Interface
- `NUM_RS_ENTRIES`, 16: number of RS entries (power of 2, ≥4); `IDX_W` = log2(`NUM_RS_ENTRIES`).
- `MULT_LAT`, 4: multiplier latency from issue cycle to CDB cycle (≥2).
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `entry_valid` input `NUM_RS_ENTRIES`: entry occupied.
- `entry_ready` input `NUM_RS_ENTRIES`: both operands ready, including a same-cycle CDB wakeup.
- `entry_fu` input `NUM_RS_ENTRIES`×2: entry unit class; 0=ALU, 1=MULT, 2=LSQ, 3=reserved, never issued.
- `lsq_ready` input 1: LSQ accepts one op this cycle.
- `issue_stall` input 1: issue register cannot accept; no grants this cycle.
- `flush` input 1: squash; cancels the in-flight multiply.
- `issue_valid` output 2: slot grant valid.
- `issue_idx` output 2×`IDX_W`: granted entry per slot.
- `issue_fu` output 2×2: class of the granted entry per slot.
- `entry_clear` output `NUM_RS_ENTRIES`: one-hot OR of granted entries; the RS frees them at the clock edge.
- `mult_busy` output 1: multiplier occupied (`mult_cnt` != 0).

## Operation
- **State**
  - `rr_ptr` [`IDX_W`]: search start.
  - `mult_cnt` [log2(`MULT_LAT`)+1]: remaining multiplier cycles.
- **Eligibility.** Entry *e* is eligible when `entry_valid[e]`, `entry_ready[e]` and `entry_fu[e]`≠3 all hold, subject to class limits:
  - **ALU:** always a candidate.
  - **MULT:** candidate only if `mult_cnt` ≤ 1. Back-to-back is allowed in the cycle the previous op leaves.
  - **LSQ:** candidate only if `lsq_ready`=1.
- **Search.** Scan entries `rr_ptr`, `rr_ptr`+1, … mod N, taking the first two that satisfy all of the following:
  - At most 1 MULT granted per cycle.
  - At most 1 LSQ granted per cycle.
  - Total grants ≤ 2 − `cdb_rsv`, where `cdb_rsv` = (`mult_cnt`==1). In that cycle the multiplier result takes one CDB slot next cycle, so only one grant is allowed.
  - A skipped entry does not block later entries.
- **Slot order.** The first granted entry in scan order goes to slot 0 and the second to slot 1. `issue_valid[1]` implies `issue_valid[0]`.
- **Suppression.** `issue_stall`=1 or `flush`=1 forces all grants to 0: `issue_valid`=0 and `entry_clear`=0.
- **`rr_ptr` update.**
  - If any grant: `rr_ptr` ← (index of the last grant + 1) mod N. Wrap-around from N−1 goes to 0.
  - Otherwise `rr_ptr` is held.
- **`mult_cnt` update, in priority order.**
  - `flush` → 0.
  - MULT granted → `MULT_LAT`−1.
  - `mult_cnt`≠0 → decrement.
  - Otherwise hold.
  - A grant in the same cycle as `mult_cnt`==1 reloads the counter; it does not decrement.
- **Reset.** `rr_ptr`=0 and `mult_cnt`=0. While `reset_n`=0, all outputs are 0: `issue_valid`, `issue_idx`, `issue_fu`, `entry_clear`, `mult_busy`.
- **Unused slots.** `issue_idx` and `issue_fu` of an invalid slot drive 0.

## Timing
- Grants are combinational from the current inputs and state, with same-cycle `entry_clear`. The RS frees entries and the issue register captures them at the next rising edge.
- ALU and LSQ results broadcast at t+1 for issue at t. A MULT issued at t broadcasts at t+`MULT_LAT`; `mult_cnt`==1 during cycle t+`MULT_LAT`−1.
- `mult_busy` rises the cycle after a MULT grant and stays high for `MULT_LAT`−1 cycles.
- **Reset mid-multiply:** asynchronous clear. No stale `cdb_rsv` after release.
- **Flush mid-multiply:** at the next cycle `mult_cnt`=0, no CDB reservation, and a MULT is immediately eligible.
- All entries invalid, or none eligible: no grants, all state held except the `mult_cnt` decrement.

## Test plan
- **Reset:** drive `reset_n`=0 with entries 0–15 valid and ready as ALU. Required: all outputs 0. After release, cycle 1 grants idx 0 and 1, and `rr_ptr`=2.
- **Wrap-around:** with `rr_ptr`=14 and eligible ALU entries {15, 0, 3}: grants slot0=15 and slot1=0, and `rr_ptr` becomes 1.
- **Class limits:** entries 2 (MULT), 4 (MULT), 5 (LSQ), 6 (LSQ) eligible, `rr_ptr`=0, `lsq_ready`=1. Required: grants 2 and 5. With `lsq_ready`=0, grants are only 2.
- **MULT occupancy, `MULT_LAT`=4:** MULT granted at cycle t; another MULT waiting. Required:
  - `mult_busy` high during t+1..t+3.
  - At t+3 (`mult_cnt`==1) only one grant total; the waiting MULT is granted at t+3.
  - `mult_cnt` reloads to 3.
- **Flush:** `flush`=1 at t+1 after a MULT grant. Required: no grants at t+1, `mult_cnt`=0 at t+2, and a MULT eligible at t+2 is granted.
- **Stall:** `issue_stall`=1 for 3 cycles with 5 eligible ALU entries. Required: `issue_valid`=0, `entry_clear`=0 and `rr_ptr` unchanged throughout. On release, two grants resume from `rr_ptr`.
